seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for DIGITS hexadecimal digits, used for on-board debug readout of internal registers. It holds a value register loadable by nibble shift or full-word write. It snapshots that register once per frame so a digit never changes mid-frame. It scans one active-low digit select at a time, with a programmable all-off gap between digits to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver; define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [3:0]            shift_nibble,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     gnds,
  output logic [6:0]            display,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int DW   = 4 * DIGITS;
  localparam int IW   = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CMAX = SCAN_DIV > GAP_CYCLES ? SCAN_DIV : GAP_CYCLES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  typedef enum logic {SHOW, GAP} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, idx_nx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          data_q, data_d;
  logic [DIGITS-1:0][3:0] snap_q;
  logic [DIGITS-1:0]      snap_dp_q;
  logic                   snap_en;
  logic [DIGITS-1:0]      lz;
  logic                   show, hide;
  logic [DIGITS-1:0]      gnds_d;
  logic [6:0]             display_d;
  logic                   dp_d, tick_d;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // value register: a full-word write beats a nibble shift
  always_comb begin
    data_d = wr_en ? wr_data : shift_en ? DW'({data_q, shift_nibble}) : data_q;
  end

  // scan sequencing: lit period per digit, optional dark gap, snapshot when digit 0 comes round
  always_comb begin
    idx_nx  = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    snap_en = 1'b0;
    if (state_q == SHOW && cnt_q == SHOW_LAST) begin
      cnt_d = '0;
      if (GAP_CYCLES > 0) begin
        state_d = GAP;
      end else begin
        idx_d   = idx_nx;
        snap_en = idx_nx == '0;
      end
    end else if (state_q == GAP && cnt_q == GAP_LAST) begin
      cnt_d   = '0;
      state_d = SHOW;
      idx_d   = idx_nx;
      snap_en = idx_nx == '0;
    end
  end

  // digit i>0 counts as a leading zero when it and every higher nibble are zero
  always_comb begin
    lz = '0;
    for (int i = 1; i < DIGITS; i++) lz[i] = LZ_EN && ((snap_q >> (4 * i)) == '0);
  end

  // pin decode of the current scan position; registered below for glitch-free pins
  always_comb begin
    show      = state_q == SHOW;
    hide      = blank[idx_q] | lz[idx_q];
    gnds_d    = show ? ~(DIGITS'(1) << idx_q) : '1;
    display_d = show && !hide ? hex_font(snap_q[idx_q]) : '0;
    dp_d      = show && !blank[idx_q] && snap_dp_q[idx_q];
    tick_d    = show && idx_q == '0 && cnt_q == '0;
  end

  // state, value, snapshot and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SHOW;
      idx_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      snap_q     <= '0;
      snap_dp_q  <= '0;
      gnds       <= '1;
      display    <= '0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      snap_q     <= snap_en ? data_q : snap_q;
      snap_dp_q  <= snap_en ? dp_in : snap_dp_q;
      gnds       <= gnds_d;
      display    <= display_d;
      dp         <= dp_d;
      frame_tick <= tick_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: vector table, directed load/reset sequences and random traffic against a time-based model
module tb_seg7_scan_driver;
  localparam int SD = 3;
  localparam int GP [2] = '{0, 2};
  localparam logic [6:0] FONT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
  localparam logic [6:0] Z = 7'h00;
`else
  localparam bit LZ = 1'b0;
  localparam logic [6:0] Z = 7'h7E;
`endif
  localparam logic [12:0] OFF = {4'hF, 9'h0};

  typedef struct {
    logic [3:0] bl;
    logic [3:0] gm;
    logic [6:0] dm;
    logic       tm;
    logic [3:0] gg;
    logic [6:0] dg;
    logic       tg;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, shift_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  shift_nibble = '0, blank = '0, dp_in = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  gnds0, gnds1;
  logic [6:0]  display0, display1;
  logic        dp0, dp1, tick0, tick1;
  logic [12:0] pins [2];
  logic [12:0] exp_p [2];
  int          mt [2];
  logic [15:0] ms [2];
  logic [3:0]  mdp [2];
  logic [15:0] m_data;
  bit          chk_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tab [13];

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(SD), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .shift_nibble(shift_nibble),
    .wr_en(wr_en), .wr_data(wr_data), .blank(blank), .dp_in(dp_in),
    .gnds(gnds0), .display(display0), .dp(dp0), .frame_tick(tick0));

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(SD), .GAP_CYCLES(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .shift_nibble(shift_nibble),
    .wr_en(wr_en), .wr_data(wr_data), .blank(blank), .dp_in(dp_in),
    .gnds(gnds1), .display(display1), .dp(dp1), .frame_tick(tick1));

  always #5 clk = ~clk;

  always_comb begin
    pins[0] = {gnds0, display0, dp0, tick0};
    pins[1] = {gnds1, display1, dp1, tick1};
  end

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // expected pins for scan time t (clocks since reset) from frame/digit arithmetic
  function automatic logic [12:0] mpins(input int t, input int g, input logic [15:0] s,
                                         input logic [3:0] sdp, input logic [3:0] bl);
    int per, p, d, off;
    logic [3:0] nib;
    bit hide;
    per = SD + g;
    p = t % (4 * per);
    d = p / per;
    off = p % per;
    if (off >= SD) return OFF;
    nib = s[4*d +: 4];
    hide = bl[d] || (LZ && d > 0 && (s >> (4 * d)) == 16'h0);
    return {~(4'b1 << d), hide ? 7'h00 : FONT[nib], !bl[d] && sdp[d], p == 0};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        exp_p[k] <= OFF;
        mt[k] <= 0;
        ms[k] <= '0;
        mdp[k] <= '0;
      end else begin
        exp_p[k] <= mpins(mt[k], GP[k], ms[k], mdp[k], blank);
        mt[k] <= mt[k] + 1;
        if ((mt[k] + 1) % (4 * (SD + GP[k])) == 0) begin
          ms[k] <= m_data;
          mdp[k] <= dp_in;
        end
      end
    end
    m_data <= !rst_n ? 16'h0 : wr_en ? wr_data : shift_en ? {m_data[11:0], shift_nibble} : m_data;
  end

  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 2; k++) chk($sformatf("model%0d", k), pins[k], exp_p[k]);

  task automatic wait_tick(input string nm);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tick0 && w < 40);
    if (!tick0) chk({nm, "_tick_timeout"}, 13'(tick0), 13'd1);
  endtask

  // skip frames, then check each digit of the next frame on the GAP_CYCLES=0 instance
  task automatic check_frame(input string nm, input int skip, input logic [3:0][6:0] e);
    for (int s = 0; s <= skip; s++) wait_tick(nm);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (SD) @(negedge clk);
      chk($sformatf("%s_d%0d", nm, d), 13'({gnds0, display0}), 13'({~(4'b1 << d), e[d]}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{4'b0000, 4'b1110, 7'h7E, 1'b1, 4'b1110, 7'h7E, 1'b1};
    tab[1]  = '{4'b0000, 4'b1110, 7'h7E, 1'b0, 4'b1110, 7'h7E, 1'b0};
    tab[2]  = '{4'b0000, 4'b1110, 7'h7E, 1'b0, 4'b1110, 7'h7E, 1'b0};
    tab[3]  = '{4'b0100, 4'b1101, Z,     1'b0, 4'b1111, 7'h00, 1'b0};
    tab[4]  = '{4'b0000, 4'b1101, Z,     1'b0, 4'b1111, 7'h00, 1'b0};
    tab[5]  = '{4'b0000, 4'b1101, Z,     1'b0, 4'b1101, Z,     1'b0};
    tab[6]  = '{4'b0100, 4'b1011, 7'h00, 1'b0, 4'b1101, Z,     1'b0};
    tab[7]  = '{4'b0100, 4'b1011, 7'h00, 1'b0, 4'b1101, Z,     1'b0};
    tab[8]  = '{4'b0100, 4'b1011, 7'h00, 1'b0, 4'b1111, 7'h00, 1'b0};
    tab[9]  = '{4'b0000, 4'b0111, Z,     1'b0, 4'b1111, 7'h00, 1'b0};
    tab[10] = '{4'b0100, 4'b0111, Z,     1'b0, 4'b1011, 7'h00, 1'b0};
    tab[11] = '{4'b0100, 4'b0111, Z,     1'b0, 4'b1011, 7'h00, 1'b0};
    tab[12] = '{4'b0000, 4'b1110, 7'h7E, 1'b1, 4'b1011, Z,     1'b0};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_main", pins[0], OFF);
    chk("reset_gap", pins[1], OFF);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      blank = tab[i].bl;
      @(negedge clk);
      chk($sformatf("vec%0d_main", i), pins[0], {tab[i].gm, tab[i].dm, 1'b0, tab[i].tm});
      chk($sformatf("vec%0d_gap", i), pins[1], {tab[i].gg, tab[i].dg, 1'b0, tab[i].tg});
    end
    blank = '0;
    repeat (2) @(negedge clk);
    wr_en = 1'b1;
    wr_data = 16'hA5C3;
    @(negedge clk);
    wr_en = 1'b0;
    check_frame("wr_a5c3", 0, {7'h77, 7'h5B, 7'h4E, 7'h79});
    for (int i = 1; i <= 4; i++) begin
      shift_en = 1'b1;
      shift_nibble = 4'(i);
      @(negedge clk);
    end
    shift_en = 1'b0;
    check_frame("shift_1234", 1, {7'h30, 7'h6D, 7'h79, 7'h33});
    wr_en = 1'b1;
    wr_data = 16'hBEEF;
    shift_en = 1'b1;
    shift_nibble = 4'h7;
    @(negedge clk);
    wr_en = 1'b0;
    shift_en = 1'b0;
    check_frame("wr_over_shift", 1, {7'h1F, 7'h4F, 7'h4F, 7'h47});
    begin
      int w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (mt[0] % 12 != 11 && w < 20);
    end
    wr_en = 1'b1;
    wr_data = 16'h0050;
    @(negedge clk);
    wr_en = 1'b0;
    check_frame("edge_wr_old", 0, {7'h1F, 7'h4F, 7'h4F, 7'h47});
    check_frame("edge_wr_new", 0, {Z, Z, 7'h5B, 7'h7E});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_main", pins[0], OFF);
    chk("midreset_gap", pins[1], OFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_main", pins[0], {4'b1110, 7'h7E, 1'b0, 1'b1});
    chk("rerelease_gap", pins[1], {4'b1110, 7'h7E, 1'b0, 1'b1});
    check_frame("after_reset", 0, {Z, Z, Z, 7'h7E});
    for (int c = 0; c < 500; c++) begin
      rst_n = c != 250;
      wr_en = $urandom_range(0, 15) == 0;
      wr_data = 16'($urandom) >> (4 * $urandom_range(0, 4));
      shift_en = $urandom_range(0, 3) == 0;
      shift_nibble = 4'($urandom);
      blank = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      dp_in = 4'($urandom);
      @(negedge clk);
    end
    {wr_en, shift_en, blank, dp_in} = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
